tdc_uart_framer: RTL and testbench

TDC_UART_FRAMER -- requirements
Module: tdc_uart_framer

---
 rtl/tdc_uart_framer.sv | 154 +++++++++++++++
 tb/tb_tdc_uart_framer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_uart_framer.sv
// Buffers 64-bit TDC measurements in a small FIFO and serialises each one as a
// 10-byte UART frame: sync byte, eight data bytes (LSB first), XOR checksum.
module tdc_uart_framer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Data_DV,
  input  logic [63:0] i_Data,
  output logic        o_Data_Ready,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_Overflow,
  output logic        o_Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACT,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            r_State;
  logic [63:0]       r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_Wr_Ptr;
  logic [PTR_W-1:0]  r_Rd_Ptr;
  logic [CNT_W-1:0]  r_Count;
  logic              r_Overflow;
  logic [63:0]       r_Shift;
  logic [3:0]        r_Index;
  logic [7:0]        r_Csum;
  logic              r_Tx_DV;
  logic [7:0]        r_Tx_Byte;

  logic w_Full;
  logic w_Empty;
  logic w_Push;
  logic w_Pop;

  // Readiness looks only at the registered count, so a pop in the same cycle
  // never rescues a write that arrives while full.
  assign w_Full       = (r_Count == FULL_CNT);
  assign w_Empty      = (r_Count == '0);
  assign w_Push       = i_Data_DV && !w_Full;
  assign w_Pop        = (r_State == IDLE) && !w_Empty;

  assign o_Data_Ready = !w_Full;
  assign o_Busy       = (r_State != IDLE) || !w_Empty;
  assign o_Overflow   = r_Overflow;
  assign o_Tx_DV      = r_Tx_DV;
  assign o_Tx_Byte    = r_Tx_Byte;

  always_ff @(posedge i_Clock) begin
    if (w_Push) begin
      r_Mem[r_Wr_Ptr] <= i_Data;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Wr_Ptr   <= '0;
      r_Rd_Ptr   <= '0;
      r_Count    <= '0;
      r_Overflow <= 1'b0;
    end else begin
      if (w_Push) begin
        r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
      end
      if (w_Pop) begin
        r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
      end
      case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + CNT_W'(1);
        2'b01:   r_Count <= r_Count - CNT_W'(1);
        default: r_Count <= r_Count;
      endcase
      if (i_Data_DV && w_Full) begin
        r_Overflow <= 1'b1;
      end
    end
  end

  // Tx outputs are loaded on the transition into ISSUE so the strobe and byte
  // are presented exactly during the ISSUE cycle and held afterwards.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State   <= IDLE;
      r_Shift   <= '0;
      r_Index   <= '0;
      r_Csum    <= '0;
      r_Tx_DV   <= 1'b0;
      r_Tx_Byte <= 8'h00;
    end else begin
      r_Tx_DV <= 1'b0;
      case (r_State)
        IDLE: begin
          if (!w_Empty) begin
            r_Shift   <= r_Mem[r_Rd_Ptr];
            r_Index   <= 4'd0;
            r_Csum    <= 8'h00;
            r_Tx_DV   <= 1'b1;
            r_Tx_Byte <= SYNC_BYTE;
            r_State   <= ISSUE;
          end
        end
        ISSUE: begin
          r_State <= WAIT_ACT;
        end
        WAIT_ACT: begin
          if (i_Tx_Active) begin
            r_State <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (i_Tx_Done && !i_Tx_Active) begin
            r_State <= GAP;
          end
        end
        GAP: begin
          // Waiting for Done to fall keeps a long Done pulse from advancing twice.
          if (!i_Tx_Done) begin
            if (r_Index == 4'd9) begin
              r_State <= IDLE;
            end else begin
              r_Index <= r_Index + 4'd1;
              r_Tx_DV <= 1'b1;
              r_State <= ISSUE;
              if (r_Index == 4'd8) begin
                r_Tx_Byte <= r_Csum;
              end else begin
                r_Tx_Byte <= r_Shift[7:0];
                r_Shift   <= {8'h00, r_Shift[63:8]};
                r_Csum    <= r_Csum ^ r_Shift[7:0];
              end
            end
          end
        end
        default: begin
          r_State <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_uart_framer.sv
// Scoreboard bench for tdc_uart_framer: expected frame bytes are queued when a
// word is written and popped by a monitor on every o_Tx_DV strobe.
module tb_tdc_uart_framer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Data_DV = 1'b0;
  logic [63:0] i_Data = '0;
  logic        i_Tx_Active = 1'b0;
  logic        i_Tx_Done = 1'b0;
  logic        o_Data_Ready;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic        o_Overflow;
  logic        o_Busy;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [7:0]  expQ[$];
  int          dvCount = 0;
  logic [7:0]  lastByte = 8'h00;
  int          uPhase = 0;
  int          uCnt = 0;

  tdc_uart_framer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Data_DV    (i_Data_DV),
    .i_Data       (i_Data),
    .o_Data_Ready (o_Data_Ready),
    .o_Tx_DV      (o_Tx_DV),
    .o_Tx_Byte    (o_Tx_Byte),
    .i_Tx_Active  (i_Tx_Active),
    .i_Tx_Done    (i_Tx_Done),
    .o_Overflow   (o_Overflow),
    .o_Busy       (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference frame: sync, the word's bytes from least significant up, XOR of those bytes.
  function automatic void pushFrame(input logic [63:0] w);
    logic [7:0] x;
    x = 8'h00;
    expQ.push_back(SYNC);
    for (int b = 0; b < 8; b++) begin
      expQ.push_back(w[8*b +: 8]);
      x = x ^ w[8*b +: 8];
    end
    expQ.push_back(x);
  endfunction

  task automatic settle(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] w, input bit addToModel);
    i_Data    = w;
    i_Data_DV = 1'b1;
    if (addToModel) pushFrame(w);
    @(posedge i_Clock);
    #1;
    i_Data_DV = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles, input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge i_Clock);
      #1;
      n++;
    end
    checkOutput({name, "_bytes_left"}, 64'(expQ.size()), 64'd0);
  endtask

  // UART model: random start delay, busy time and Done hold (1-3 cycles).
  initial begin
    forever begin
      @(posedge i_Clock);
      #1;
      if (i_Reset) begin
        i_Tx_Active = 1'b0;
        i_Tx_Done   = 1'b0;
        uPhase      = 0;
      end else begin
        case (uPhase)
          0: if (o_Tx_DV) begin uCnt = $urandom_range(0, 2); uPhase = 1; end
          1: if (uCnt == 0) begin i_Tx_Active = 1'b1; uCnt = $urandom_range(1, 4); uPhase = 2; end
             else uCnt--;
          2: if (uCnt <= 1) begin i_Tx_Active = 1'b0; i_Tx_Done = 1'b1; uCnt = $urandom_range(1, 3); uPhase = 3; end
             else uCnt--;
          default: if (uCnt <= 1) begin i_Tx_Done = 1'b0; uPhase = 0; end
             else uCnt--;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge i_Clock);
      if (i_Reset) begin
        lastByte = 8'h00;
      end else if (o_Tx_DV) begin
        dvCount++;
        checkOutput("tx_while_uart_idle", {62'd0, i_Tx_Active, i_Tx_Done}, 64'd0);
        if (expQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL unexpected_tx: got byte %02h, expected no strobe", o_Tx_Byte);
        end else begin
          checkOutput("tx_byte", 64'(o_Tx_Byte), 64'(expQ.pop_front()));
        end
        lastByte = o_Tx_Byte;
      end else begin
        checkOutput("tx_byte_hold", 64'(o_Tx_Byte), 64'(lastByte));
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: got no finish, expected bench completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] refA [10];
    int base;
    int n;
    int outstanding;
    refA = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h00};

    settle(3);
    checkOutput("rst_ready",    64'(o_Data_Ready), 64'd1);
    checkOutput("rst_busy",     64'(o_Busy),       64'd0);
    checkOutput("rst_tx_dv",    64'(o_Tx_DV),      64'd0);
    checkOutput("rst_tx_byte",  64'(o_Tx_Byte),    64'd0);
    checkOutput("rst_overflow", 64'(o_Overflow),   64'd0);
    i_Reset = 1'b0;
    settle(2);

    // Known word with literal expected frame, plus first-byte latency.
    base = dvCount;
    for (int i = 0; i < 10; i++) expQ.push_back(refA[i]);
    applyStimulus(64'h0123_4567_89AB_CDEF, 1'b0);
    checkOutput("latency_pop_cycle_dv", 64'(o_Tx_DV), 64'd0);
    settle(1);
    checkOutput("latency_issue_dv",   64'(o_Tx_DV),   64'd1);
    checkOutput("latency_issue_byte", 64'(o_Tx_Byte), 64'(SYNC));
    waitDrain(500, "frame_a");
    checkOutput("frame_a_strobes", 64'(dvCount - base), 64'd10);
    settle(12);
    checkOutput("frame_a_busy_after", 64'(o_Busy), 64'd0);

    // Two words back-to-back.
    base = dvCount;
    applyStimulus({$urandom, $urandom}, 1'b1);
    applyStimulus({$urandom, $urandom}, 1'b1);
    n = 0;
    while (expQ.size() > 10 && n < 500) begin settle(1); n++; end
    checkOutput("two_first_frame_done", 64'(expQ.size()), 64'd10);
    checkOutput("two_busy_between", 64'(o_Busy), 64'd1);
    waitDrain(500, "two_frames");
    checkOutput("two_busy_last_byte", 64'(o_Busy), 64'd1);
    settle(12);
    checkOutput("two_strobes", 64'(dvCount - base), 64'd20);
    checkOutput("two_busy_after", 64'(o_Busy), 64'd0);

    // Five consecutive writes fill a depth-4 FIFO; the sixth is dropped.
    for (int k = 0; k < 5; k++) begin
      checkOutput("ovf_ready_before_write", 64'(o_Data_Ready), 64'd1);
      applyStimulus({$urandom, $urandom}, 1'b1);
    end
    checkOutput("ovf_ready_full", 64'(o_Data_Ready), 64'd0);
    checkOutput("ovf_flag_before", 64'(o_Overflow), 64'd0);
    applyStimulus({$urandom, $urandom}, 1'b0);
    checkOutput("ovf_flag_set", 64'(o_Overflow), 64'd1);
    checkOutput("ovf_still_full", 64'(o_Data_Ready), 64'd0);
    waitDrain(3000, "ovf_frames");
    settle(12);
    checkOutput("ovf_flag_sticky", 64'(o_Overflow), 64'd1);
    checkOutput("ovf_busy_after", 64'(o_Busy), 64'd0);

    // Reset after the 4th byte with two words still queued.
    base = dvCount;
    for (int k = 0; k < 3; k++) applyStimulus({$urandom, $urandom}, 1'b1);
    n = 0;
    while (dvCount < base + 4 && n < 500) begin settle(1); n++; end
    checkOutput("mid_frame_reached", 64'(dvCount >= base + 4), 64'd1);
    @(posedge i_Clock);
    #2;
    i_Reset = 1'b1;
    #1;
    checkOutput("midrst_tx_dv",    64'(o_Tx_DV),      64'd0);
    checkOutput("midrst_tx_byte",  64'(o_Tx_Byte),    64'd0);
    checkOutput("midrst_overflow", 64'(o_Overflow),   64'd0);
    checkOutput("midrst_busy",     64'(o_Busy),       64'd0);
    checkOutput("midrst_ready",    64'(o_Data_Ready), 64'd1);
    expQ.delete();
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;
    base = dvCount;
    settle(40);
    checkOutput("postrst_no_strobes", 64'(dvCount - base), 64'd0);
    checkOutput("postrst_busy", 64'(o_Busy), 64'd0);

    // Randomised traffic, writing only when the model guarantees room.
    for (int i = 0; i < 40; i++) begin
      settle($urandom_range(0, 25));
      outstanding = (expQ.size() + 9) / 10;
      if (outstanding < DEPTH) begin
        checkOutput("rand_ready", 64'(o_Data_Ready), 64'd1);
        applyStimulus({$urandom, $urandom}, 1'b1);
      end
    end
    waitDrain(20000, "random");
    settle(12);
    checkOutput("rand_busy_after", 64'(o_Busy), 64'd0);
    checkOutput("rand_no_overflow", 64'(o_Overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
